arc4_seq: RTL and testbench

Top-level sequencer for the ARC4 decrypt path. Runs the three S-memory engines (`init`, `ksa`, `prga`) in order via their `en`/`rdy` handshakes, and grants the single-port S memory to whichever engine is active. It sits between the top-level wrapper (key source, start) and the engine instances. It latches the key, flags illegal writes from engines that do not own the memory, and gives the top level one `en`/`rdy` handshake for the whole decrypt.

---
 rtl/arc4_pkg.sv | 36 +++
 rtl/arc4_seq_s_port_mux.sv | 55 +++++
 rtl/arc4_seq.sv | 104 ++++++++++
 tb/tb_arc4_seq.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arc4_pkg.sv
// ARC4 sequencer package: FSM state and S-memory owner encodings, key width,
// and the state-to-owner decode used by the sequencer.
package arc4_pkg;

    localparam int KEY_W = 24;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        INIT_START = 3'd1,
        INIT_WAIT  = 3'd2,
        KSA_START  = 3'd3,
        KSA_WAIT   = 3'd4,
        PRGA_START = 3'd5,
        PRGA_WAIT  = 3'd6,
        DONE       = 3'd7
    } seq_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INIT = 2'd1,
        OWN_KSA  = 2'd2,
        OWN_PRGA = 2'd3
    } s_owner_t;

    // An engine owns the S port for both its START and WAIT states, so its
    // address is already on the port in the cycle its start pulse goes out.
    function automatic s_owner_t owner_of(input seq_state_t s);
        case (s)
            INIT_START, INIT_WAIT: return OWN_INIT;
            KSA_START,  KSA_WAIT:  return OWN_KSA;
            PRGA_START, PRGA_WAIT: return OWN_PRGA;
            default:               return OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/arc4_seq_s_port_mux.sv
// s_port_mux: combinational 3:1 mux of the engine S-memory ports onto the
// single S port, plus detection of writes from engines that do not own it.
//   owner                   : current owner (OWN_NONE parks the port at 0)
//   init_/ksa_/prga_*       : engine addr, wrdata, wren
//   s_addr/s_wrdata/s_wren  : to S memory
//   illegal_wr              : some non-owner has wren asserted this cycle
module s_port_mux
    import arc4_pkg::*;
(
    input  s_owner_t    owner,
    input  logic [7:0]  init_addr,
    input  logic [7:0]  init_wrdata,
    input  logic        init_wren,
    input  logic [7:0]  ksa_addr,
    input  logic [7:0]  ksa_wrdata,
    input  logic        ksa_wren,
    input  logic [7:0]  prga_addr,
    input  logic [7:0]  prga_wrdata,
    input  logic        prga_wren,
    output logic [7:0]  s_addr,
    output logic [7:0]  s_wrdata,
    output logic        s_wren,
    output logic        illegal_wr
);

    always_comb begin
        s_addr   = 8'd0;
        s_wrdata = 8'd0;
        s_wren   = 1'b0;
        case (owner)
            OWN_INIT: begin
                s_addr   = init_addr;
                s_wrdata = init_wrdata;
                s_wren   = init_wren;
            end
            OWN_KSA: begin
                s_addr   = ksa_addr;
                s_wrdata = ksa_wrdata;
                s_wren   = ksa_wren;
            end
            OWN_PRGA: begin
                s_addr   = prga_addr;
                s_wrdata = prga_wrdata;
                s_wren   = prga_wren;
            end
            default: ;
        endcase
    end

    // With no owner every engine is a non-owner, so any write is illegal.
    assign illegal_wr = (init_wren && (owner != OWN_INIT)) ||
                        (ksa_wren  && (owner != OWN_KSA))  ||
                        (prga_wren && (owner != OWN_PRGA));

endmodule

// File: rtl/arc4_seq.sv
// arc4_seq: top-level sequencer for the ARC4 decrypt path. Runs init, ksa and
// prga in order through their en/rdy handshakes, grants the single-port S
// memory to the active engine, latches the key and flags illegal writes.
//   clk, rst               : clock, synchronous active-high reset
//   en, rdy                : whole-decrypt handshake (en sampled while rdy=1)
//   key, key_q             : key input, key latched on the accepting edge
//   x_en, x_rdy            : per-engine start pulse / ready (x = init,ksa,prga)
//   x_addr/x_wrdata/x_wren : per-engine S port requests
//   s_addr/s_wrdata/s_wren : S memory port
//   err                    : sticky illegal (non-owner) write flag
module arc4_seq
    import arc4_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             rdy,
    input  logic [KEY_W-1:0] key,
    output logic [KEY_W-1:0] key_q,
    output logic             init_en,
    output logic             ksa_en,
    output logic             prga_en,
    input  logic             init_rdy,
    input  logic             ksa_rdy,
    input  logic             prga_rdy,
    input  logic [7:0]       init_addr,
    input  logic [7:0]       ksa_addr,
    input  logic [7:0]       prga_addr,
    input  logic [7:0]       init_wrdata,
    input  logic [7:0]       ksa_wrdata,
    input  logic [7:0]       prga_wrdata,
    input  logic             init_wren,
    input  logic             ksa_wren,
    input  logic             prga_wren,
    output logic [7:0]       s_addr,
    output logic [7:0]       s_wrdata,
    output logic             s_wren,
    output logic             err
);

    seq_state_t state, state_nxt;
    logic       guard;       // high in the first cycle of any x_WAIT state
    logic       illegal_wr;
    s_owner_t   owner;

    assign rdy     = (state == IDLE);
    assign init_en = (state == INIT_START) && init_rdy;
    assign ksa_en  = (state == KSA_START)  && ksa_rdy;
    assign prga_en = (state == PRGA_START) && prga_rdy;
    assign owner   = owner_of(state);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (en)                 state_nxt = INIT_START;
            INIT_START: if (init_rdy)           state_nxt = INIT_WAIT;
            // The engine still shows its old rdy=1 in the guard cycle.
            INIT_WAIT:  if (!guard && init_rdy) state_nxt = KSA_START;
            KSA_START:  if (ksa_rdy)            state_nxt = KSA_WAIT;
            KSA_WAIT:   if (!guard && ksa_rdy)  state_nxt = PRGA_START;
            PRGA_START: if (prga_rdy)           state_nxt = PRGA_WAIT;
            PRGA_WAIT:  if (!guard && prga_rdy) state_nxt = DONE;
            DONE:                               state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            guard <= 1'b0;
            key_q <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            // Every start pulse moves the FSM into a WAIT state.
            guard <= init_en || ksa_en || prga_en;
            if (rdy && en) begin
                key_q <= key;
                err   <= 1'b0;
            end else if (illegal_wr) begin
                err <= 1'b1;
            end
        end
    end

    s_port_mux u_mux (
        .owner       (owner),
        .init_addr   (init_addr),
        .init_wrdata (init_wrdata),
        .init_wren   (init_wren),
        .ksa_addr    (ksa_addr),
        .ksa_wrdata  (ksa_wrdata),
        .ksa_wren    (ksa_wren),
        .prga_addr   (prga_addr),
        .prga_wrdata (prga_wrdata),
        .prga_wren   (prga_wren),
        .s_addr      (s_addr),
        .s_wrdata    (s_wrdata),
        .s_wren      (s_wren),
        .illegal_wr  (illegal_wr)
    );

endmodule

// File: tb/tb_arc4_seq.sv
// Bench for arc4_seq: stub engines with programmable latency, randomized
// S-port traffic checked against an ownership/latency reference model.
module tb_arc4_seq;

    logic        clk = 1'b0;
    logic        rst, en, rdy, err, s_wren;
    logic [23:0] key, key_q;
    logic        init_en, ksa_en, prga_en, init_rdy, ksa_rdy, prga_rdy;
    logic [7:0]  s_addr, s_wrdata;
    logic [7:0]  a_in [3];
    logic [7:0]  d_in [3];
    logic [2:0]  w_in;

    logic [2:0]  eng_en, eng_rdy, rdy_r, busy_r, hold;
    int          lat [3];
    int          cnt [3];
    int          en_tot [3];
    int          t_pulse [3];
    int          cyc;
    int          n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    arc4_seq dut (
        .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key), .key_q(key_q),
        .init_en(init_en), .ksa_en(ksa_en), .prga_en(prga_en),
        .init_rdy(init_rdy), .ksa_rdy(ksa_rdy), .prga_rdy(prga_rdy),
        .init_addr(a_in[0]), .ksa_addr(a_in[1]), .prga_addr(a_in[2]),
        .init_wrdata(d_in[0]), .ksa_wrdata(d_in[1]), .prga_wrdata(d_in[2]),
        .init_wren(w_in[0]), .ksa_wren(w_in[1]), .prga_wren(w_in[2]),
        .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren), .err(err)
    );

    assign eng_en  = {prga_en, ksa_en, init_en};
    assign eng_rdy = rdy_r & ~hold;
    assign init_rdy = eng_rdy[0];
    assign ksa_rdy  = eng_rdy[1];
    assign prga_rdy = eng_rdy[2];

    // Stub engine: samples en at edge s, drops rdy, and shows rdy=1 again so
    // that it is observed at edge s+lat.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                rdy_r[i]  <= 1'b1;
                busy_r[i] <= 1'b0;
                cnt[i]    <= 0;
            end else if (eng_en[i] && eng_rdy[i]) begin
                rdy_r[i]  <= 1'b0;
                busy_r[i] <= 1'b1;
                cnt[i]    <= 1;
                en_tot[i] <= en_tot[i] + 1;
                t_pulse[i] <= cyc;
            end else if (busy_r[i]) begin
                if (cnt[i] >= lat[i] - 1) begin
                    rdy_r[i]  <= 1'b1;
                    busy_r[i] <= 1'b0;
                end else begin
                    cnt[i] <= cnt[i] + 1;
                end
            end
        end
    end

    initial begin
        cyc = 0;
        for (int i = 0; i < 3; i++) begin
            en_tot[i] = 0;
            t_pulse[i] = 0;
        end
    end

    task automatic wait_idle(output bit to);
        to = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rdy === 1'b1) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic quiet();
        w_in = 3'b000;
        for (int i = 0; i < 3; i++) begin
            a_in[i] = 8'($urandom);
            d_in[i] = 8'($urandom);
        end
    endtask

    // One full decrypt with random traffic; returns the edge-observed latency
    // and counts of cycles where the port, err or key_q disagreed with model.
    task automatic run(input logic [23:0] k, input int l0, input int l1,
                       input int l2, input int poke, output int n,
                       output int mux_bad, output int err_bad,
                       output int kq_bad, output bit to);
        bit err_exp, pend;
        int o;
        lat[0] = l0; lat[1] = l1; lat[2] = l2;
        n = 0; mux_bad = 0; err_bad = 0; kq_bad = 0;
        err_exp = 1'b0; pend = 1'b0;
        quiet();
        wait_idle(to);
        if (to) return;
        en = 1'b1;
        key = k;
        @(posedge clk);
        to = 1'b1;
        while (n < 400) begin
            @(negedge clk);
            n++;
            en = (n == poke);
            if (pend) err_exp = 1'b1;
            pend = 1'b0;
            if (err !== err_exp) err_bad++;
            if (key_q !== k) kq_bad++;
            key = 24'($urandom);
            if (rdy === 1'b1) begin
                to = 1'b0;
                break;
            end
            quiet();
            if (|busy_r) begin
                w_in = 3'($urandom);
                o = busy_r[0] ? 0 : (busy_r[1] ? 1 : 2);
                #1;
                if (s_addr !== a_in[o] || s_wrdata !== d_in[o] || s_wren !== w_in[o])
                    mux_bad++;
                for (int i = 0; i < 3; i++)
                    if (i != o && w_in[i]) pend = 1'b1;
            end
        end
        en = 1'b0;
        quiet();
        #1;
        if (s_addr !== 8'd0 || s_wrdata !== 8'd0 || s_wren !== 1'b0) mux_bad++;
    endtask

    task automatic test_reset();
        en = 1'b0; key = 24'hABCDEF; hold = 3'b000;
        lat[0] = 2; lat[1] = 2; lat[2] = 2;
        quiet();
        w_in = 3'b111;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL reset_rdy got=%b exp=1", rdy); end
        n_cmp++; if (s_wren !== 1'b0) begin n_bad++; $display("FAIL reset_s_wren got=%b exp=0", s_wren); end
        n_cmp++; if (s_addr !== 8'd0) begin n_bad++; $display("FAIL reset_s_addr got=%h exp=00", s_addr); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", err); end
        n_cmp++; if (key_q !== 24'd0) begin n_bad++; $display("FAIL reset_key_q got=%h exp=0", key_q); end
        n_cmp++; if (eng_en !== 3'b000) begin n_bad++; $display("FAIL reset_x_en got=%b exp=000", eng_en); end
        w_in = 3'b000;
        rst = 1'b0;
    endtask

    task automatic test_full_run();
        int n, mb, eb, kb, b[3], t0;
        bit to;
        for (int i = 0; i < 3; i++) b[i] = en_tot[i];
        t0 = cyc;
        run(24'h000018, 4, 6, 3, 0, n, mb, eb, kb, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL full_timeout"); end
        n_cmp++; if (n != 5 + 4 + 6 + 3) begin n_bad++; $display("FAIL full_latency got=%0d exp=%0d", n, 18); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (en_tot[i] - b[i] != 1) begin n_bad++; $display("FAIL full_pulses eng=%0d got=%0d exp=1", i, en_tot[i] - b[i]); end
        end
        n_cmp++;
        if (!(t_pulse[0] >= t0 && t_pulse[0] < t_pulse[1] && t_pulse[1] < t_pulse[2])) begin
            n_bad++; $display("FAIL full_order got=%0d,%0d,%0d", t_pulse[0], t_pulse[1], t_pulse[2]);
        end
        n_cmp++; if (mb != 0) begin n_bad++; $display("FAIL full_mux bad_cycles=%0d exp=0", mb); end
        n_cmp++; if (eb != 0) begin n_bad++; $display("FAIL full_err bad_cycles=%0d exp=0", eb); end
        n_cmp++; if (kb != 0) begin n_bad++; $display("FAIL full_key_q bad_cycles=%0d exp=0", kb); end
        n_cmp++; if (key_q !== 24'h000018) begin n_bad++; $display("FAIL full_key_q_end got=%h exp=000018", key_q); end
    endtask

    task automatic test_random_runs();
        int n, mb, eb, kb, l0, l1, l2;
        bit to;
        for (int r = 0; r < 4; r++) begin
            l0 = int'($urandom_range(9, 2));
            l1 = int'($urandom_range(9, 2));
            l2 = int'($urandom_range(9, 2));
            run(24'($urandom), l0, l1, l2, 0, n, mb, eb, kb, to);
            n_cmp++;
            if (to || n != 5 + l0 + l1 + l2) begin
                n_bad++; $display("FAIL rand_latency run=%0d got=%0d exp=%0d to=%b", r, n, 5 + l0 + l1 + l2, to);
            end
            n_cmp++;
            if (mb != 0 || eb != 0 || kb != 0) begin
                n_bad++; $display("FAIL rand_checks run=%0d mux=%0d err=%0d key=%0d exp=0", r, mb, eb, kb);
            end
        end
    endtask

    task automatic test_ownership();
        bit to;
        int bad;
        lat[0] = 4; lat[1] = 6; lat[2] = 3;
        quiet();
        wait_idle(to);
        en = 1'b1; key = 24'h123456;
        @(negedge clk);
        en = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy_r[1]) begin to = 1'b0; break; end
        end
        n_cmp++; if (to) begin n_bad++; $display("FAIL own_ksa_wait_timeout"); end
        a_in[1] = 8'h5A; w_in = 3'b010;
        #1;
        n_cmp++; if (s_addr !== 8'h5A) begin n_bad++; $display("FAIL own_s_addr got=%h exp=5a", s_addr); end
        n_cmp++; if (s_wren !== 1'b1) begin n_bad++; $display("FAIL own_s_wren got=%b exp=1", s_wren); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL own_err_pre got=%b exp=0", err); end
        @(negedge clk);
        w_in = 3'b100;
        #1;
        n_cmp++; if (s_wren !== 1'b0) begin n_bad++; $display("FAIL own_nonowner_fwd got=%b exp=0", s_wren); end
        @(negedge clk);
        w_in = 3'b110;
        #1;
        n_cmp++; if (s_wren !== 1'b1 || s_addr !== 8'h5A) begin n_bad++; $display("FAIL own_both got=%b/%h exp=1/5a", s_wren, s_addr); end
        @(negedge clk);
        w_in = 3'b000;
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL own_err_set got=%b exp=1", err); end
        bad = 0; to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (err !== 1'b1) bad++;
            if (rdy === 1'b1) begin to = 1'b0; break; end
        end
        n_cmp++; if (to || bad != 0) begin n_bad++; $display("FAIL own_err_sticky bad=%0d exp=0 to=%b", bad, to); end
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL own_err_clear got=%b exp=0", err); end
        wait_idle(to);
    endtask

    task automatic test_busy_engine();
        bit to;
        int b[3], bad;
        for (int i = 0; i < 3; i++) b[i] = en_tot[i];
        lat[0] = 3; lat[1] = 4; lat[2] = 2;
        quiet();
        wait_idle(to);
        hold = 3'b010;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (ksa_en !== 1'b0) bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL busy_ksa_en got=%0d_cycles exp=0", bad); end
        n_cmp++; if (rdy !== 1'b0 || en_tot[1] != b[1]) begin n_bad++; $display("FAIL busy_hold rdy=%b pulses=%0d exp=0/0", rdy, en_tot[1] - b[1]); end
        hold = 3'b000;
        wait_idle(to);
        n_cmp++;
        if (to || en_tot[0] - b[0] != 1 || en_tot[1] - b[1] != 1 || en_tot[2] - b[2] != 1) begin
            n_bad++; $display("FAIL busy_release pulses=%0d,%0d,%0d exp=1,1,1 to=%b",
                              en_tot[0] - b[0], en_tot[1] - b[1], en_tot[2] - b[2], to);
        end
    endtask

    task automatic test_reset_mid_run();
        bit to;
        int n, mb, eb, kb, b0;
        lat[0] = 4; lat[1] = 5; lat[2] = 8;
        quiet();
        wait_idle(to);
        en = 1'b1; key = 24'hC0FFEE;
        @(negedge clk);
        en = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy_r[2]) begin to = 1'b0; break; end
        end
        n_cmp++; if (to) begin n_bad++; $display("FAIL rstmid_prga_wait_timeout"); end
        w_in = 3'b100;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL rstmid_rdy got=%b exp=1", rdy); end
        n_cmp++; if (s_wren !== 1'b0) begin n_bad++; $display("FAIL rstmid_s_wren got=%b exp=0", s_wren); end
        n_cmp++; if (key_q !== 24'd0) begin n_bad++; $display("FAIL rstmid_key_q got=%h exp=0", key_q); end
        w_in = 3'b000;
        rst = 1'b0;
        b0 = en_tot[0];
        run(24'h0A0B0C, 3, 3, 3, 0, n, mb, eb, kb, to);
        n_cmp++;
        if (to || n != 14 || en_tot[0] - b0 != 1 || mb != 0 || eb != 0 || kb != 0) begin
            n_bad++; $display("FAIL rstmid_restart lat=%0d exp=14 init=%0d mux=%0d err=%0d key=%0d to=%b",
                              n, en_tot[0] - b0, mb, eb, kb, to);
        end
    endtask

    task automatic test_ignored_start();
        int n, mb, eb, kb, b0;
        bit to;
        b0 = en_tot[0];
        run(24'h777777, 4, 6, 3, 3, n, mb, eb, kb, to);
        n_cmp++; if (to || n != 18) begin n_bad++; $display("FAIL ignored_latency got=%0d exp=18 to=%b", n, to); end
        n_cmp++; if (en_tot[0] - b0 != 1) begin n_bad++; $display("FAIL ignored_init_pulses got=%0d exp=1", en_tot[0] - b0); end
        n_cmp++; if (key_q !== 24'h777777) begin n_bad++; $display("FAIL ignored_key_q got=%h exp=777777", key_q); end
    endtask

    task automatic test_back_to_back();
        bit to;
        int first, second, s, b0;
        lat[0] = int'($urandom_range(6, 2));
        lat[1] = int'($urandom_range(6, 2));
        lat[2] = int'($urandom_range(6, 2));
        s = 5 + lat[0] + lat[1] + lat[2];
        quiet();
        wait_idle(to);
        b0 = en_tot[0];
        en = 1'b1;
        @(posedge clk);
        first = 0; second = 0;
        for (int n = 1; n < 400; n++) begin
            @(negedge clk);
            if (rdy === 1'b1) begin
                if (first == 0) first = n;
                else begin second = n; break; end
            end
        end
        en = 1'b0;
        n_cmp++; if (first != s) begin n_bad++; $display("FAIL b2b_first got=%0d exp=%0d", first, s); end
        n_cmp++; if (second != 2 * s) begin n_bad++; $display("FAIL b2b_second got=%0d exp=%0d", second, 2 * s); end
        n_cmp++; if (en_tot[0] - b0 != 2) begin n_bad++; $display("FAIL b2b_init_pulses got=%0d exp=2", en_tot[0] - b0); end
        @(negedge clk);
        n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL b2b_idle_after got=%b exp=1", rdy); end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; hold = 3'b000; key = '0; w_in = '0;
        test_reset();
        test_full_run();
        test_random_runs();
        test_ownership();
        test_busy_engine();
        test_reset_mid_run();
        test_ignored_start();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
